// File: rtl/cdc_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : cdc_pulse_stretcher
// Purpose  : Widens and spaces per-lane event pulses so that a slower
//            destination-clock synchronizer can sample every high and low.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_pulse_stretcher #(
    parameter int DATA_BITS  = 1,
    parameter int STRETCH    = 3,
    parameter int GAP        = 2,
    parameter int PEND_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] pulse_in,
    input  logic [DATA_BITS-1:0] clear_ovf,
    output logic [DATA_BITS-1:0] pulse_out,
    output logic [DATA_BITS-1:0] busy,
    output logic [DATA_BITS-1:0] overflow
);

    localparam int c_CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_PEND_W  = $clog2(PEND_DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_STRETCH_LD = c_CNT_W'(STRETCH - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LD     = c_CNT_W'(GAP - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_PEND_W-1:0] c_PEND_ONE   = c_PEND_W'(1);
    localparam logic [c_PEND_W-1:0] c_PEND_FULL  = c_PEND_W'(PEND_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    for (genvar i = 0; i < DATA_BITS; i++) begin : g_lane
        state_t                r_state;
        logic [c_CNT_W-1:0]    r_cnt;
        logic [c_PEND_W-1:0]   r_pend;
        logic                  r_pulse;
        logic                  r_busy;
        logic                  r_ovf;

        logic w_ev;
        logic w_cnt_zero;
        logic w_accept;
        logic w_queue;
        logic w_drop;

        assign w_ev       = pulse_in[i];
        assign w_cnt_zero = (r_cnt == '0);
        // Events are queued while a pulse is in flight, except on the LOW
        // exit cycle where they are folded into the restart decision.
        assign w_accept   = (r_state == S_HIGH) || ((r_state == S_LOW) && !w_cnt_zero);
        assign w_queue    = w_accept && w_ev && (r_pend != c_PEND_FULL);
        assign w_drop     = w_accept && w_ev && (r_pend == c_PEND_FULL);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pend  <= '0;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ev) begin
                            r_state <= S_HIGH;
                            r_cnt   <= c_STRETCH_LD;
                            r_pulse <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end else begin
                            r_state <= S_LOW;
                            r_cnt   <= c_GAP_LD;
                            r_pulse <= 1'b0;
                        end
                    end
                    S_LOW: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end else if ((r_pend != '0) || w_ev) begin
                            r_state <= S_HIGH;
                            r_cnt   <= c_STRETCH_LD;
                            r_pulse <= 1'b1;
                            // pend - 1 + E: unchanged when a new event replaces the one consumed
                            if ((r_pend != '0) && !w_ev) begin
                                r_pend <= r_pend - c_PEND_ONE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_pend  <= '0;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase

                if (w_queue) begin
                    r_pend <= r_pend + c_PEND_ONE;
                end

                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (clear_ovf[i]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign pulse_out[i] = r_pulse;
        assign busy[i]      = r_busy;
        assign overflow[i]  = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_cdc_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_pulse_stretcher
// Purpose  : Directed self-checking bench for cdc_pulse_stretcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic [1:0] pulse_in;
    logic [1:0] clear_ovf;
    logic [1:0] pulse_out;
    logic [1:0] busy;
    logic [1:0] overflow;

    int total;
    int bad;

    cdc_pulse_stretcher #(
        .DATA_BITS (2),
        .STRETCH   (3),
        .GAP       (2),
        .PEND_DEPTH(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .clear_ovf(clear_ovf),
        .pulse_out(pulse_out),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs then show the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After this returns the bench is in cycle 0, reset released.
    task automatic do_reset();
        reset     = 1'b1;
        pulse_in  = 2'b00;
        clear_ovf = 2'b00;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pulse_in  = 2'b11;
        clear_ovf = 2'b00;
        step();
        step();
        total++; if (pulse_out !== 2'b00) begin bad++; $display("FAIL reset_pulse_out got=%b want=00", pulse_out); end
        total++; if (busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", busy); end
        total++; if (overflow !== 2'b00) begin bad++; $display("FAIL reset_overflow got=%b want=00", overflow); end
        pulse_in = 2'b00;
        reset    = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] exp_p, exp_b;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c == 10) ? 2'b01 : 2'b00;
            exp_p = {1'b0, (c >= 11 && c <= 13)};
            exp_b = {1'b0, (c >= 11 && c <= 15)};
            total++; if (pulse_out !== exp_p) begin bad++; $display("FAIL single_pulse cyc=%0d got=%b want=%b", c, pulse_out, exp_p); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=%b", c, busy, exp_b); end
            step();
        end
    endtask

    task automatic test_exit_event();
        logic [1:0] exp_p, exp_b;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            pulse_in = (c == 10 || c == 15) ? 2'b01 : 2'b00;
            exp_p = {1'b0, ((c >= 11 && c <= 13) || (c >= 16 && c <= 18))};
            exp_b = {1'b0, (c >= 11 && c <= 20)};
            total++; if (pulse_out !== exp_p) begin bad++; $display("FAIL exit_pulse cyc=%0d got=%b want=%b", c, pulse_out, exp_p); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL exit_busy cyc=%0d got=%b want=%b", c, busy, exp_b); end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_p, exp_o;
        logic       prev;
        int         rises;
        rises = 0;
        prev  = 1'b0;
        do_reset();
        for (int c = 0; c <= 28; c++) begin
            pulse_in = (c >= 10 && c <= 13) ? 2'b01 : 2'b00;
            exp_p = {1'b0, ((c >= 11 && c <= 13) || (c >= 16 && c <= 18) || (c >= 21 && c <= 23))};
            exp_o = {1'b0, (c >= 14)};
            if (pulse_out[0] && !prev) rises++;
            prev = pulse_out[0];
            total++; if (pulse_out !== exp_p) begin bad++; $display("FAIL ovf_pulse cyc=%0d got=%b want=%b", c, pulse_out, exp_p); end
            total++; if (overflow !== exp_o) begin bad++; $display("FAIL ovf_flag cyc=%0d got=%b want=%b", c, overflow, exp_o); end
            step();
        end
        total++; if (rises !== 3) begin bad++; $display("FAIL ovf_count got=%0d want=3", rises); end
    endtask

    task automatic test_ovf_priority();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            pulse_in  = (c <= 3) ? 2'b01 : 2'b00;
            clear_ovf = (c == 3 || c == 5) ? 2'b01 : 2'b00;
            if (c == 3) begin
                total++; if (overflow[0] !== 1'b0) begin bad++; $display("FAIL prio_before got=%b want=0", overflow[0]); end
            end
            if (c == 4 || c == 5) begin
                total++; if (overflow[0] !== 1'b1) begin bad++; $display("FAIL prio_set_wins cyc=%0d got=%b want=1", c, overflow[0]); end
            end
            if (c >= 6) begin
                total++; if (overflow[0] !== 1'b0) begin bad++; $display("FAIL prio_clear cyc=%0d got=%b want=0", c, overflow[0]); end
            end
            step();
        end
        clear_ovf = 2'b00;
    endtask

    // Events at 0..7; drops at 3,4,6,7 (the cycle-5 exit event re-queues), so 4 pulses.
    task automatic test_continuous();
        logic [1:0] exp_p, exp_o;
        logic       prev;
        int         rises;
        rises = 0;
        prev  = 1'b0;
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            pulse_in = (c <= 7) ? 2'b10 : 2'b00;
            exp_p = {((c >= 1 && c <= 3) || (c >= 6 && c <= 8) || (c >= 11 && c <= 13) || (c >= 16 && c <= 18)), 1'b0};
            exp_o = {(c >= 4), 1'b0};
            if (pulse_out[1] && !prev) rises++;
            prev = pulse_out[1];
            total++; if (pulse_out !== exp_p) begin bad++; $display("FAIL cont_pulse cyc=%0d got=%b want=%b", c, pulse_out, exp_p); end
            total++; if (overflow !== exp_o) begin bad++; $display("FAIL cont_ovf cyc=%0d got=%b want=%b", c, overflow, exp_o); end
            step();
        end
        total++; if (rises !== 4) begin bad++; $display("FAIL cont_count got=%0d want=4", rises); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_p, exp_b;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            reset    = (c == 12);
            pulse_in = (c == 10 || c == 12 || c == 13) ? 2'b01 : 2'b00;
            exp_p = {1'b0, ((c >= 11 && c <= 12) || (c >= 14 && c <= 16))};
            exp_b = {1'b0, ((c >= 11 && c <= 12) || (c >= 14 && c <= 18))};
            total++; if (pulse_out !== exp_p) begin bad++; $display("FAIL rstmid_pulse cyc=%0d got=%b want=%b", c, pulse_out, exp_p); end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL rstmid_busy cyc=%0d got=%b want=%b", c, busy, exp_b); end
            if (c == 13) begin
                total++; if (overflow !== 2'b00) begin bad++; $display("FAIL rstmid_ovf got=%b want=00", overflow); end
            end
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        pulse_in  = 2'b00;
        clear_ovf = 2'b00;
        test_reset();
        test_single();
        test_exit_event();
        test_overflow();
        test_ovf_priority();
        test_continuous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
